// File: rtl/sram_xfer_pkg.sv
// rtl/sram_xfer_pkg.sv - shared constants, state encoding and helpers for the SRAM transfer sequencer
package sram_xfer_pkg;

    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 7;
    localparam int LEN_W   = 7;
    localparam int MAX_LEN = 64;

    localparam logic DIR_0TO1 = 1'b0;
    localparam logic DIR_1TO0 = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } xfer_state_t;

    // Requests longer than one full macro are cut down to the macro depth
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] req_len);
        return (req_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : req_len;
    endfunction

endpackage

// File: rtl/sram_xfer_addr_gen.sv
// rtl/sram_xfer_addr_gen.sv - source/destination address counters and remaining-word down-counter
module sram_xfer_addr_gen
    import sram_xfer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [LEN_W-1:0]  count,
    output logic [ADDR_W-1:0] src_addr,
    output logic [ADDR_W-1:0] dst_addr,
    output logic              wr_phase,
    output logic              last
);

    logic [LEN_W-1:0] remaining;

    // Read pointer advances every RUN cycle; write pointer only once writes have started,
    // so it always trails the read pointer by exactly one word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_addr  <= '0;
            dst_addr  <= '0;
            remaining <= '0;
            wr_phase  <= 1'b0;
        end else if (load) begin
            src_addr  <= src_base;
            dst_addr  <= dst_base;
            remaining <= count;
            wr_phase  <= 1'b0;
        end else if (step) begin
            src_addr  <= src_addr + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
            wr_phase  <= 1'b1;
            if (wr_phase) begin
                dst_addr <= dst_addr + ADDR_W'(1);
            end
        end
    end

    assign last = (remaining == LEN_W'(1));

endmodule

// File: rtl/sram_xfer_sequencer.sv
// rtl/sram_xfer_sequencer.sv - copy sequencer driving two cross-wired 64x7 SRAM macros
module sram_xfer_sequencer
    import sram_xfer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              dir,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [6:0]        len,
    input  logic [DATA_W-1:0] wmask,
    output logic              busy,
    output logic              done,
    output logic              sram0_ce_in,
    output logic              sram0_we_in,
    output logic [ADDR_W-1:0] sram0_addr_in,
    output logic [DATA_W-1:0] sram0_w_mask_in,
    output logic              sram1_ce_in,
    output logic              sram1_we_in,
    output logic [ADDR_W-1:0] sram1_addr_in,
    output logic [DATA_W-1:0] sram1_w_mask_in
);

    xfer_state_t       state;
    xfer_state_t       state_next;
    logic              dir_q;
    logic [DATA_W-1:0] wmask_q;
    logic              done_q;
    logic              done_next;
    logic              load;
    logic              step;
    logic              last;
    logic              wr_phase;
    logic [LEN_W-1:0]  len_c;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;

    assign len_c = clamp_len(len);

    sram_xfer_addr_gen u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .step     (step),
        .src_base (src_base),
        .dst_base (dst_base),
        .count    (len_c),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .wr_phase (wr_phase),
        .last     (last)
    );

    // State, completion pulse and the per-transfer settings captured at the accept edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            done_q  <= 1'b0;
            dir_q   <= DIR_0TO1;
            wmask_q <= '0;
        end else begin
            state  <= state_next;
            done_q <= done_next;
            if (load) begin
                dir_q   <= dir;
                wmask_q <= wmask;
            end
        end
    end

    // Next-state: zero-length requests complete straight from IDLE without touching the macros
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len_c == '0) begin
                        done_next = 1'b1;
                    end else begin
                        load       = 1'b1;
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Macro pin decode from registered state only; the source side is steered by the latched dir
    always_comb begin
        logic              src_rd;
        logic              dst_wr;
        logic [ADDR_W-1:0] rd_addr;
        logic [ADDR_W-1:0] wr_addr;
        logic [DATA_W-1:0] wr_mask;

        src_rd  = (state == RUN);
        dst_wr  = ((state == RUN) && wr_phase) || (state == FLUSH);
        rd_addr = src_rd ? src_addr : '0;
        wr_addr = dst_wr ? dst_addr : '0;
        wr_mask = dst_wr ? wmask_q  : '0;

        busy = (state != IDLE);
        done = done_q;

        sram0_ce_in     = 1'b0;
        sram0_we_in     = 1'b0;
        sram0_addr_in   = '0;
        sram0_w_mask_in = '0;
        sram1_ce_in     = 1'b0;
        sram1_we_in     = 1'b0;
        sram1_addr_in   = '0;
        sram1_w_mask_in = '0;

        if (dir_q == DIR_0TO1) begin
            sram0_ce_in     = src_rd;
            sram0_addr_in   = rd_addr;
            sram1_ce_in     = dst_wr;
            sram1_we_in     = dst_wr;
            sram1_addr_in   = wr_addr;
            sram1_w_mask_in = wr_mask;
        end else begin
            sram1_ce_in     = src_rd;
            sram1_addr_in   = rd_addr;
            sram0_ce_in     = dst_wr;
            sram0_we_in     = dst_wr;
            sram0_addr_in   = wr_addr;
            sram0_w_mask_in = wr_mask;
        end
    end

endmodule

// File: tb/tb_sram_xfer_sequencer.sv
// tb/tb_sram_xfer_sequencer.sv - self-checking bench for sram_xfer_sequencer with cross-wired macro models
module tb_sram_xfer_sequencer;
    import sram_xfer_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       dir = 1'b0;
    logic [5:0] src_base = '0;
    logic [5:0] dst_base = '0;
    logic [6:0] len = '0;
    logic [6:0] wmask = '0;
    logic       busy, done;
    logic       sram0_ce_in, sram0_we_in, sram1_ce_in, sram1_we_in;
    logic [5:0] sram0_addr_in, sram1_addr_in;
    logic [6:0] sram0_w_mask_in, sram1_w_mask_in;

    sram_xfer_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .dir             (dir),
        .src_base        (src_base),
        .dst_base        (dst_base),
        .len             (len),
        .wmask           (wmask),
        .busy            (busy),
        .done            (done),
        .sram0_ce_in     (sram0_ce_in),
        .sram0_we_in     (sram0_we_in),
        .sram0_addr_in   (sram0_addr_in),
        .sram0_w_mask_in (sram0_w_mask_in),
        .sram1_ce_in     (sram1_ce_in),
        .sram1_we_in     (sram1_we_in),
        .sram1_addr_in   (sram1_addr_in),
        .sram1_w_mask_in (sram1_w_mask_in)
    );

    logic [6:0] pl0 [64];
    logic [6:0] pl1 [64];
    logic       pl_go = 1'b0;
    logic       cnt_clr = 1'b0;

    // Macro models: 1-cycle registered read, masked write of the other macro's read register
    logic [6:0] mem0 [64];
    logic [6:0] mem1 [64];
    logic [6:0] rd0 = '0;
    logic [6:0] rd1 = '0;
    int rd_cnt = 0, wr_cnt = 0, busy_cnt = 0;
    always @(posedge clk) begin : harness
        logic [6:0] r0, r1;
        r0 = rd0;
        r1 = rd1;
        if (pl_go) for (int i = 0; i < 64; i++) begin mem0[i] = pl0[i]; mem1[i] = pl1[i]; end
        if (sram0_ce_in && !sram0_we_in) rd0 = mem0[sram0_addr_in];
        if (sram1_ce_in && !sram1_we_in) rd1 = mem1[sram1_addr_in];
        if (sram0_ce_in && sram0_we_in)
            mem0[sram0_addr_in] = (mem0[sram0_addr_in] & ~sram0_w_mask_in) | (r1 & sram0_w_mask_in);
        if (sram1_ce_in && sram1_we_in)
            mem1[sram1_addr_in] = (mem1[sram1_addr_in] & ~sram1_w_mask_in) | (r0 & sram1_w_mask_in);
        if (cnt_clr) begin
            rd_cnt = 0; wr_cnt = 0; busy_cnt = 0;
        end else begin
            if (sram0_ce_in && !sram0_we_in) rd_cnt++;
            if (sram1_ce_in && !sram1_we_in) rd_cnt++;
            if (sram0_ce_in && sram0_we_in) wr_cnt++;
            if (sram1_ce_in && sram1_we_in) wr_cnt++;
            if (busy) busy_cnt++;
        end
    end

    // Reference model: a transfer is a cycle index k = 0..Lc (k = Lc is the flush cycle)
    bit         m_active = 0, m_done = 0, m_dir = 0;
    int         m_k = 0, m_len = 0, m_src = 0, m_dst = 0;
    logic [6:0] m_wm = '0;
    logic [6:0] ref0 [64];
    logic [6:0] ref1 [64];
    always @(posedge clk) begin : model
        int sa, da;
        if (pl_go) for (int i = 0; i < 64; i++) begin ref0[i] = pl0[i]; ref1[i] = pl1[i]; end
        if (!rst_n) begin
            m_active = 0;
            m_done   = 0;
        end else begin
            m_done = 0;
            if (m_active) begin
                if (m_k == m_len) begin
                    m_active = 0;
                    m_done   = 1;
                    for (int i = 0; i < m_len; i++) begin
                        sa = (m_src + i) % 64;
                        da = (m_dst + i) % 64;
                        if (!m_dir) ref1[da] = (ref1[da] & ~m_wm) | (ref0[sa] & m_wm);
                        else        ref0[da] = (ref0[da] & ~m_wm) | (ref1[sa] & m_wm);
                    end
                end else begin
                    m_k++;
                end
            end else if (start) begin
                m_len = (int'(len) > 64) ? 64 : int'(len);
                if (m_len == 0) begin
                    m_done = 1;
                end else begin
                    m_active = 1; m_k = 0;
                    m_src = int'(src_base); m_dst = int'(dst_base);
                    m_dir = dir; m_wm = wmask;
                end
            end
        end
    end

    function automatic logic [31:0] model_vec();
        logic        rd, wr;
        logic [14:0] src_p, dst_p;
        rd    = m_active && (m_k < m_len);
        wr    = m_active && (m_k >= 1);
        src_p = rd ? {1'b1, 1'b0, 6'((m_src + m_k) % 64), 7'h00} : 15'h0;
        dst_p = wr ? {1'b1, 1'b1, 6'((m_dst + m_k - 1) % 64), m_wm} : 15'h0;
        return m_dir ? {m_active, m_done, dst_p, src_p} : {m_active, m_done, src_p, dst_p};
    endfunction

    function automatic logic [31:0] act_vec();
        return {busy, done, sram0_ce_in, sram0_we_in, sram0_addr_in, sram0_w_mask_in,
                sram1_ce_in, sram1_we_in, sram1_addr_in, sram1_w_mask_in};
    endfunction

    int n_err = 0, n_chk = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Every cycle: compare all outputs against the model away from the active edge
    task automatic tick();
        @(negedge clk);
        check("outputs", act_vec(), model_vec());
        #1;
    endtask

    task automatic scramble();
        dir = 1'($urandom); src_base = 6'($urandom); dst_base = 6'($urandom);
        len = 7'($urandom); wmask = 7'($urandom);
    endtask

    task automatic issue(input bit d, input logic [5:0] s, input logic [5:0] ds,
                         input logic [6:0] l, input logic [6:0] w);
        dir = d; src_base = s; dst_base = ds; len = l; wmask = w; start = 1'b1;
        tick();
        start = 1'b0;
        scramble();
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!m_done && cyc < 300) begin tick(); cyc++; end
        check("done_timeout", 32'(m_done), 32'd1);
    endtask

    task automatic check_mem();
        int bad = 0;
        for (int i = 0; i < 64; i++) if (mem0[i] !== ref0[i] || mem1[i] !== ref1[i]) bad++;
        check("mem_contents", 32'(bad), 32'd0);
    endtask

    task automatic preload_rand();
        for (int i = 0; i < 64; i++) begin pl0[i] = 7'($urandom); pl1[i] = 7'($urandom); end
        pl_go = 1'b1; tick(); pl_go = 1'b0;
    endtask

    initial begin : stim
        int cyc;
        for (int i = 0; i < 64; i++) begin pl0[i] = 7'($urandom); pl1[i] = 7'($urandom); end
        tick(); tick();
        check("reset_outputs", act_vec(), 32'h0);
        rst_n = 1'b1;
        pl_go = 1'b1; tick(); pl_go = 1'b0;
        tick();

        // Reset mid-idle for two cycles
        rst_n = 1'b0; tick(); tick();
        check("idle_reset_outputs", act_vec(), 32'h0);
        rst_n = 1'b1; tick();

        // Basic copy sram0 -> sram1
        for (int i = 0; i < 64; i++) begin pl0[i] = 7'($urandom); pl1[i] = 7'($urandom); end
        for (int i = 0; i < 4; i++) pl0[i] = 7'(8'h11 + i);
        pl_go = 1'b1; tick(); pl_go = 1'b0;
        issue(0, 6'd0, 6'h10, 7'd4, 7'h7F);
        wait_done(cyc);
        check("basic_done_cycle", 32'(cyc), 32'd6);
        check("basic_dst_data", {4'h0, mem1[16], mem1[17], mem1[18], mem1[19]},
              {4'h0, 7'h11, 7'h12, 7'h13, 7'h14});
        check_mem();
        tick();

        // Wrapping copy sram1 -> sram0
        for (int i = 0; i < 64; i++) begin pl0[i] = 7'($urandom); pl1[i] = 7'(i) ^ 7'h55; end
        pl_go = 1'b1; tick(); pl_go = 1'b0;
        issue(1, 6'd62, 6'd63, 7'd3, 7'h7F);
        wait_done(cyc);
        check("wrap_dst_data", {11'h0, mem0[63], mem0[0], mem0[1]}, {11'h0, 7'h6B, 7'h6A, 7'h55});
        check_mem();
        tick();

        // Zero length and clamped length
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        issue(0, 6'd5, 6'd9, 7'd0, 7'h7F);
        wait_done(cyc);
        check("len0_done_cycle", 32'(cyc), 32'd1);
        tick();
        check("len0_no_access", 32'(rd_cnt + wr_cnt + busy_cnt), 32'd0);
        issue(1, 6'd7, 6'd40, 7'd100, 7'h7F);
        wait_done(cyc);
        check("len100_reads", 32'(rd_cnt), 32'd64);
        check("len100_writes", 32'(wr_cnt), 32'd64);
        check("len100_busy", 32'(busy_cnt), 32'd65);
        check_mem();

        // Start during RUN is ignored; back-to-back start in the done cycle is accepted
        issue(0, 6'd20, 6'd30, 7'd8, 7'h2A);
        tick(); start = 1'b1; tick(); start = 1'b0; tick();
        wait_done(cyc);
        check_mem();
        issue(1, 6'd1, 6'd2, 7'd5, 7'h7F);
        wait_done(cyc);
        check_mem();

        // Reset at k=2 abandons the transfer without done; a later transfer runs normally
        issue(0, 6'd10, 6'd12, 7'd10, 7'h7F);
        tick(); tick();
        rst_n = 1'b0; tick();
        check("abort_outputs", act_vec(), 32'h0);
        rst_n = 1'b1;
        repeat (4) tick();
        preload_rand();
        issue(0, 6'd3, 6'd50, 7'd6, 7'h7F);
        wait_done(cyc);
        check_mem();

        // Partial write mask
        for (int i = 0; i < 64; i++) begin pl0[i] = 7'h00; pl1[i] = 7'h7F; end
        pl_go = 1'b1; tick(); pl_go = 1'b0;
        issue(0, 6'd0, 6'd8, 7'd5, 7'h0F);
        wait_done(cyc);
        check("mask_result", 32'(mem1[10]), 32'h70);
        check_mem();

        // Randomised transfers with random gaps, including zero-gap chaining
        preload_rand();
        for (int t = 0; t < 30; t++) begin
            repeat ($urandom_range(0, 2)) tick();
            issue(1'($urandom), 6'($urandom), 6'($urandom),
                  ($urandom_range(0, 5) == 0) ? 7'($urandom) : 7'($urandom_range(0, 20)),
                  7'($urandom));
            if ($urandom_range(0, 3) == 0) begin start = 1'b1; tick(); start = 1'b0; end
            wait_done(cyc);
            check_mem();
        end
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
